// File: rtl/cache_nway_pkg.sv
// Shared types and width helpers for the N-way set-associative cache.
package cache_nway_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } state_t;

  function automatic int unsigned way_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned line_bits(input int unsigned off);
    return 8 * (2 ** off);
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Tree pseudo-LRU state for every set: one heap-ordered tree of num_ways-1 bits per set.
module cache_plru
  import cache_nway_pkg::*;
#(
  parameter int unsigned s_index  = 3,
  parameter int unsigned num_ways = 4,
  parameter int unsigned s_way    = way_bits(num_ways)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_index-1:0] set,
  input  logic [s_way-1:0]   way,
  input  logic               update,
  output logic [s_way-1:0]   victim
);

  localparam int unsigned num_sets = 2 ** s_index;

  logic [num_ways-2:0] tree [num_sets];
  logic [num_ways-2:0] next_bits;
  logic [s_way-1:0]    node;
  logic [s_way-1:0]    unode;

  // The root splits on way bit 0, each deeper level on the next bit up;
  // a bit of 0 sends the victim search to the bit-0 (left) child.
  always_comb begin
    node   = '0;
    victim = '0;
    for (int unsigned l = 0; l < s_way; l++) begin
      victim[l] = tree[set][node];
      node      = s_way'(2 * int'(node) + 1 + int'(tree[set][node]));
    end
  end

  always_comb begin
    next_bits = tree[set];
    unode     = '0;
    for (int unsigned l = 0; l < s_way; l++) begin
      next_bits[unode] = ~way[l];
      unode            = s_way'(2 * int'(unode) + 1 + int'(way[l]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < num_sets; s++) tree[s] <= '0;
    end else if (update) begin
      tree[set] <= next_bits;
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache with flip-flop arrays and tree PLRU.
module cache_nway
  import cache_nway_pkg::*;
#(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 3,
  parameter int unsigned s_tag    = 32 - s_offset - s_index,
  parameter int unsigned s_line   = line_bits(s_offset),
  parameter int unsigned num_ways = 4,
  parameter int unsigned s_way    = way_bits(num_ways)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_byte_enable,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_wdata
);

  localparam int unsigned num_sets = 2 ** s_index;

  logic [s_line-1:0]   data_arr  [num_ways][num_sets];
  logic [s_tag-1:0]    tag_arr   [num_ways][num_sets];
  logic [num_ways-1:0] valid_arr [num_sets];
  logic [num_ways-1:0] dirty_arr [num_sets];

  state_t state, next_state;

  logic [s_tag-1:0]    tag;
  logic [s_index-1:0]  index;
  logic [s_offset+2:0] word_lsb;
  logic                req, hit, access, found;
  logic [num_ways-1:0] hit_vec;
  logic [s_way-1:0]    hit_way, inv_way, plru_victim, victim_next, victim_q;

  assign tag      = mem_address[31:s_offset+s_index];
  assign index    = mem_address[s_offset+s_index-1:s_offset];
  // Bit position of the addressed 32-bit word inside the line.
  assign word_lsb = {mem_address[s_offset-1:0], 3'b000} & ~(s_offset+3)'(31);
  assign req      = mem_read | mem_write;
  assign hit      = |hit_vec;
  assign access   = (state == IDLE) && req && hit && !rst;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int unsigned w = 0; w < num_ways; w++) begin
      hit_vec[w] = valid_arr[index][w] && (tag_arr[w][index] == tag);
      if (hit_vec[w]) hit_way = s_way'(w);
    end
  end

  always_comb begin
    found   = 1'b0;
    inv_way = '0;
    for (int unsigned w = 0; w < num_ways; w++) begin
      if (!valid_arr[index][w] && !found) begin
        inv_way = s_way'(w);
        found   = 1'b1;
      end
    end
    victim_next = found ? inv_way : plru_victim;
  end

  cache_plru #(
    .s_index  (s_index),
    .num_ways (num_ways),
    .s_way    (s_way)
  ) u_plru (
    .clk    (clk),
    .rst    (rst),
    .set    (index),
    .way    (hit_way),
    .update (access),
    .victim (plru_victim)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:
        if (req && !hit)
          next_state = (valid_arr[index][victim_next] && dirty_arr[index][victim_next])
                       ? WRITEBACK : FILL;
      WRITEBACK: if (pmem_resp) next_state = FILL;
      FILL:      if (pmem_resp) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {tag, index, {s_offset{1'b0}}};
    pmem_wdata   = data_arr[victim_q][index];
    mem_rdata    = data_arr[hit_way][index][word_lsb +: 32];
    unique case (state)
      IDLE: mem_resp = req && hit && !rst;
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[victim_q][index], index, {s_offset{1'b0}}};
      end
      FILL:    pmem_read = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req && !hit) victim_q <= victim_next;
    if (state == FILL && pmem_resp) begin
      data_arr[victim_q][index] <= pmem_rdata;
      tag_arr[victim_q][index]  <= tag;
    end else if (access && mem_write) begin
      for (int unsigned i = 0; i < 4; i++)
        if (mem_byte_enable[i])
          data_arr[hit_way][index][word_lsb + 8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < num_sets; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
      end
    end else if (state == FILL && pmem_resp) begin
      valid_arr[index][victim_q] <= 1'b1;
      dirty_arr[index][victim_q] <= 1'b0;
    end else if (access && mem_write) begin
      dirty_arr[index][hit_way] <= 1'b1;
    end
  end

  a_single_hit: assert property (@(posedge clk) disable iff (rst)
    req |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_cache_nway.sv
// Self-checking bench: flat reference memory, scoreboard of expected read data, logged pmem traffic.
module tb_cache_nway;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address, mem_wdata;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;

  logic         b_mem_read;
  logic [31:0]  b_mem_address;
  logic [31:0]  b_mem_rdata;
  logic         b_mem_resp;
  logic [127:0] b_pmem_rdata;
  logic         b_pmem_resp;
  logic         b_pmem_read, b_pmem_write;
  logic [31:0]  b_pmem_address;
  logic [127:0] b_pmem_wdata;

  always #5 clk = ~clk;

  cache_nway dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata)
  );

  cache_nway #(.s_offset(4), .num_ways(2)) dut_b (
    .clk(clk), .rst(rst), .mem_read(b_mem_read), .mem_write(1'b0),
    .mem_address(b_mem_address), .mem_wdata(32'h0), .mem_byte_enable(4'h0),
    .mem_rdata(b_mem_rdata), .mem_resp(b_mem_resp), .pmem_rdata(b_pmem_rdata),
    .pmem_resp(b_pmem_resp), .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
    .pmem_address(b_pmem_address), .pmem_wdata(b_pmem_wdata)
  );

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } pev_t;

  int           n_checks = 0;
  int           n_err    = 0;
  int           overlap  = 0;
  int           b_writes = 0;
  bit           hold_resp = 1'b0;
  int           lat_cnt  = 0;
  pev_t         log_q[$];
  logic [31:0]  b_log[$];
  logic [31:0]  exp_q[$];
  logic [255:0] bk_mem [logic [31:0]];
  logic [31:0]  ref_mem [logic [31:0]];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'hA5A5_1234;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] la);
    logic [255:0] l;
    if (bk_mem.exists(la)) return bk_mem[la];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = pat(la + 32'(4*w));
    return l;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0]  wa;
    logic [255:0] l;
    wa = a & ~32'h3;
    if (ref_mem.exists(wa)) return ref_mem[wa];
    l = line_of(a & ~32'h1F);
    return l[32*int'(a[4:2]) +: 32];
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = ref_word(la + 32'(4*w));
    return l;
  endfunction

  function automatic int n_ev(input bit wr);
    int n = 0;
    foreach (log_q[i]) if (log_q[i].wr == wr) n++;
    return n;
  endfunction

  // Physical memory for the default build: fixed 3-cycle latency, optional hold.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_read && pmem_write) overlap++;
      if (pmem_resp) pmem_resp = 1'b0;
      else if (rst || hold_resp || !(pmem_read || pmem_write)) lat_cnt = 0;
      else if (lat_cnt < 2) lat_cnt++;
      else begin
        lat_cnt   = 0;
        pmem_resp = 1'b1;
        if (pmem_write) begin
          bk_mem[pmem_address] = pmem_wdata;
          log_q.push_back('{1'b1, pmem_address, pmem_wdata});
        end else begin
          pmem_rdata = line_of(pmem_address);
          log_q.push_back('{1'b0, pmem_address, 256'h0});
        end
      end
    end
  end

  initial begin
    b_pmem_resp  = 1'b0;
    b_pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (b_pmem_resp) b_pmem_resp = 1'b0;
      else if (!rst && (b_pmem_read || b_pmem_write)) begin
        b_pmem_resp = 1'b1;
        if (b_pmem_write) b_writes++;
        for (int w = 0; w < 4; w++) b_pmem_rdata[32*w +: 32] = pat(b_pmem_address + 32'(4*w));
        b_log.push_back(b_pmem_address);
      end
    end
  end

  task automatic cpu_req(input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    int          cyc;
    logic [31:0] w, e;
    if (wr) begin
      w = ref_word(addr);
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
      ref_mem[addr & ~32'h3] = w;
    end else begin
      exp_q.push_back(ref_word(addr));
    end
    mem_address = addr; mem_wdata = wdata; mem_byte_enable = be;
    mem_read = !wr; mem_write = wr;
    cyc = 0;
    #1;
    while (!mem_resp && cyc < 200) begin
      @(negedge clk); #1; cyc++;
    end
    check("mem_resp_seen", 256'(mem_resp), 256'(1));
    if (!wr) begin
      e = exp_q.pop_front();
      if (mem_resp) check($sformatf("rdata@%0h", addr), 256'(mem_rdata), 256'(e));
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic b_req(input logic [31:0] addr);
    int          cyc;
    logic [31:0] e;
    exp_q.push_back(pat(addr));
    b_mem_address = addr; b_mem_read = 1'b1;
    cyc = 0;
    #1;
    while (!b_mem_resp && cyc < 100) begin
      @(negedge clk); #1; cyc++;
    end
    check("b_mem_resp_seen", 256'(b_mem_resp), 256'(1));
    e = exp_q.pop_front();
    if (b_mem_resp) check($sformatf("b_rdata@%0h", addr), 256'(b_mem_rdata), 256'(e));
    @(negedge clk);
    b_mem_read = 1'b0;
  endtask

  initial begin
    int          cyc;
    logic [31:0] b_addrs [6];
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
    b_mem_read = 1'b0; b_mem_address = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pmem_read", 256'(pmem_read), 256'(0));
    check("rst_pmem_write", 256'(pmem_write), 256'(0));
    check("rst_mem_resp", 256'(mem_resp), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    // cold miss then fill
    log_q.delete();
    cpu_req(1'b0, 32'h40, 32'h0, 4'h0);
    check("s1_reads", 256'(n_ev(0)), 256'(1));
    check("s1_writes", 256'(n_ev(1)), 256'(0));
    if (log_q.size() > 0) check("s1_addr", 256'(log_q[0].addr), 256'(32'h40));

    // partial write then read-back on a hit
    log_q.delete();
    cpu_req(1'b1, 32'h44, 32'hDEAD_BEEF, 4'b0101);
    cpu_req(1'b0, 32'h44, 32'h0, 4'h0);
    check("s2_traffic", 256'(log_q.size()), 256'(0));

    // fill the rest of set 2 (0x140 left dirty), then a hit on 0x040
    log_q.delete();
    cpu_req(1'b1, 32'h140, 32'h1234_5678, 4'b1111);
    cpu_req(1'b0, 32'h240, 32'h0, 4'h0);
    cpu_req(1'b0, 32'h340, 32'h0, 4'h0);
    check("s3_fills", 256'(n_ev(0)), 256'(3));
    check("s3_wbs", 256'(n_ev(1)), 256'(0));
    log_q.delete();
    cpu_req(1'b0, 32'h40, 32'h0, 4'h0);
    check("s3_rehit_traffic", 256'(log_q.size()), 256'(0));

    // eviction of way 1 (dirty 0x140): writeback then fill
    log_q.delete();
    cpu_req(1'b0, 32'h440, 32'h0, 4'h0);
    check("s4_events", 256'(log_q.size()), 256'(2));
    if (log_q.size() == 2) begin
      check("s4_wb_first", 256'(log_q[0].wr), 256'(1));
      check("s4_wb_addr", 256'(log_q[0].addr), 256'(32'h140));
      check("s4_wb_data", log_q[0].data, ref_line(32'h140));
      check("s4_fill_addr", 256'(log_q[1].addr), 256'(32'h440));
    end
    log_q.delete();
    cpu_req(1'b0, 32'h240, 32'h0, 4'h0);
    cpu_req(1'b0, 32'h340, 32'h0, 4'h0);
    cpu_req(1'b0, 32'h48, 32'h0, 4'h0);
    check("s4_survivors_hit", 256'(log_q.size()), 256'(0));
    cpu_req(1'b0, 32'h144, 32'h0, 4'h0);
    check("s4_evicted_refill", 256'(n_ev(0)), 256'(1));
    check("s4_evicted_wbs", 256'(n_ev(1)), 256'(0));

    // reset in the middle of a fill
    hold_resp = 1'b1;
    mem_address = 32'h540; mem_read = 1'b1;
    cyc = 0;
    #1;
    while (!pmem_read && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    check("s5_fill_started", 256'(pmem_read), 256'(1));
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk); #1;
    check("s5_read_dropped", 256'(pmem_read), 256'(0));
    check("s5_write_low", 256'(pmem_write), 256'(0));
    check("s5_resp_low", 256'(mem_resp), 256'(0));
    @(negedge clk);
    rst = 1'b0; hold_resp = 1'b0;
    ref_mem.delete();
    log_q.delete();
    cpu_req(1'b0, 32'h540, 32'h0, 4'h0);
    check("s5_refill", 256'(n_ev(0)), 256'(1));
    log_q.delete();
    cpu_req(1'b0, 32'h44, 32'h0, 4'h0);
    check("s5_valid_cleared", 256'(n_ev(0)), 256'(1));

    // two-way, 16-byte-line build: three tags thrash one set
    b_addrs = '{32'h14, 32'h94, 32'h114, 32'h14, 32'h94, 32'h114};
    foreach (b_addrs[i]) begin
      b_log.delete();
      b_req(b_addrs[i]);
      check($sformatf("b_fill_%0d", i), 256'(b_log.size()), 256'(1));
      if (b_log.size() == 1) begin
        check($sformatf("b_addr_%0d", i), 256'(b_log[0]), 256'(b_addrs[i] & ~32'hF));
        check($sformatf("b_low_%0d", i), 256'(b_log[0][3:0]), 256'(0));
      end
    end
    b_log.delete();
    b_req(32'h118);
    check("b_last_hit", 256'(b_log.size()), 256'(0));
    check("b_no_wb", 256'(b_writes), 256'(0));
    check("pmem_rw_overlap", 256'(overlap), 256'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
